phat_hien_chuoi_param: RTL and testbench

//   Parametrised serial pattern detector, successor to the fixed 1011 detector.

---
 rtl/phat_hien_chuoi_param_if.sv | 32 +++
 rtl/phat_hien_chuoi_param.sv | 102 ++++++++++
 tb/tb_phat_hien_chuoi_param.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phat_hien_chuoi_param_if.sv
// Bus bundle for the parametrised serial pattern detector.
// master: drives data/config/clear and reads results; slave: the detector side.
// Signals: w_vld, w, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_cnt,
//          y, match_cnt, cnt_sat, cfg_err.
interface phat_hien_chuoi_param_if #(
   parameter int unsigned PAT_MAX = 8,
   parameter int unsigned CNT_W   = 8
) ();
   localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);

   logic               w_vld;
   logic               w;
   logic               cfg_load;
   logic [PAT_MAX-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               clr_cnt;
   logic               y;
   logic [CNT_W-1:0]   match_cnt;
   logic               cnt_sat;
   logic               cfg_err;

   modport master (
      output w_vld, w, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_cnt,
      input  y, match_cnt, cnt_sat, cfg_err
   );

   modport slave (
      input  w_vld, w, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_cnt,
      output y, match_cnt, cnt_sat, cfg_err
   );
endinterface

// File: rtl/phat_hien_chuoi_param.sv
// Runtime-programmable serial pattern detector with overlap control and
// saturating match counter. Ports: clk, rs_n (async low), bus (slave side).
module phat_hien_chuoi_param #(
   parameter int unsigned        PAT_MAX     = 8,
   parameter int unsigned        CNT_W       = 8,
   parameter logic [PAT_MAX-1:0] DEF_PATTERN = PAT_MAX'(8'b0000_1011),
   parameter int unsigned        DEF_LEN     = 4,
   parameter logic               DEF_OVL     = 1'b1
) (
   input logic                   clk,
   input logic                   rs_n,
   phat_hien_chuoi_param_if.slave bus
);
   localparam int unsigned      LEN_W   = $clog2(PAT_MAX + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_MAX-1:0] pat, pat_nx;
   logic [PAT_MAX-1:0] hist, hist_nx;
   logic [PAT_MAX-1:0] nh, mask;
   logic [LEN_W-1:0]   len, len_nx;
   logic [LEN_W-1:0]   fill, fill_nx, nf;
   logic               ovl, ovl_nx;
   logic               hit, cfg_ok;
   logic               y_q, y_nx;
   logic               err_q, err_nx;
   logic [CNT_W-1:0]   cnt_q, cnt_nx;
   logic               sat_q, sat_nx;

   always_comb begin
      nh     = {hist[PAT_MAX-2:0], bus.w};
      nf     = (fill == LEN_MAX) ? fill : fill + 1'b1;
      // only the low len bits of pattern and history take part
      mask   = ~({PAT_MAX{1'b1}} << len);
      hit    = (nf >= len) && (((nh ^ pat) & mask) == '0);
      cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);

      pat_nx  = pat;
      len_nx  = len;
      ovl_nx  = ovl;
      hist_nx = hist;
      fill_nx = fill;
      y_nx    = 1'b0;
      err_nx  = 1'b0;

      if (bus.cfg_load) begin
         hist_nx = '0;
         fill_nx = '0;
         if (cfg_ok) begin
            pat_nx = bus.cfg_pattern;
            len_nx = bus.cfg_len;
            ovl_nx = bus.cfg_overlap;
         end else begin
            err_nx = 1'b1;
         end
      end else if (bus.w_vld) begin
         hist_nx = nh;
         y_nx    = hit;
         // non-overlap: history is forgotten once a match is taken
         fill_nx = (hit && !ovl) ? '0 : nf;
      end

      cnt_nx = cnt_q;
      sat_nx = sat_q;
      if (bus.clr_cnt) begin
         cnt_nx = '0;
         sat_nx = 1'b0;
      end else if (y_nx && (cnt_q != CNT_MAX)) begin
         cnt_nx = cnt_q + 1'b1;
         sat_nx = sat_q | (cnt_nx == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rs_n) begin
      if (!rs_n) begin
         pat   <= DEF_PATTERN;
         len   <= LEN_W'(DEF_LEN);
         ovl   <= DEF_OVL;
         hist  <= '0;
         fill  <= '0;
         y_q   <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         pat   <= pat_nx;
         len   <= len_nx;
         ovl   <= ovl_nx;
         hist  <= hist_nx;
         fill  <= fill_nx;
         y_q   <= y_nx;
         err_q <= err_nx;
         cnt_q <= cnt_nx;
         sat_q <= sat_nx;
      end
   end

   assign bus.y         = y_q;
   assign bus.match_cnt = cnt_q;
   assign bus.cnt_sat   = sat_q;
   assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_phat_hien_chuoi_param.sv
// Self-checking bench for phat_hien_chuoi_param (CNT_W=2 to reach saturation).
// Expected y per driven bit is queued at drive time and popped after the edge.
module tb_phat_hien_chuoi_param;
   localparam int PM = 8;
   localparam int CW = 2;
   localparam int LW = $clog2(PM + 1);

   logic clk = 1'b0;
   logic rs_n;
   int   checks = 0;
   int   errors = 0;
   logic sb[$];

   phat_hien_chuoi_param_if #(.PAT_MAX(PM), .CNT_W(CW)) bus ();

   phat_hien_chuoi_param #(.PAT_MAX(PM), .CNT_W(CW)) dut (
      .clk  (clk),
      .rs_n (rs_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input logic b, input logic e);
      sb.push_back(e);
      bus.w_vld = v;
      bus.w     = b;
      tick();
      bus.w_vld = 1'b0;
   endtask

   task automatic cfg(input logic [PM-1:0] p, input logic [LW-1:0] l,
                      input logic o, input logic c);
      bus.cfg_load    = 1'b1;
      bus.cfg_pattern = p;
      bus.cfg_len     = l;
      bus.cfg_overlap = o;
      bus.clr_cnt     = c;
      tick();
      bus.cfg_load = 1'b0;
      bus.clr_cnt  = 1'b0;
   endtask

   task automatic test_reset();
      rs_n = 1'b0;
      bus.w_vld = 0; bus.w = 0; bus.cfg_load = 0; bus.clr_cnt = 0;
      bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
      #3;
      checks++;
      if ({bus.y, bus.match_cnt, bus.cnt_sat, bus.cfg_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset outs got %b exp 00000",
                  {bus.y, bus.match_cnt, bus.cnt_sat, bus.cfg_err});
      end
      #9 rs_n = 1'b1;
   endtask

   task automatic test_overlap();
      logic [6:0] s = 7'b1011011;
      logic [6:0] e = 7'b0001001;
      logic x;
      for (int i = 6; i >= 0; i--) begin
         send(1'b1, s[i], e[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t1_y bit%0d got %b exp %b", 7 - i, bus.y, x);
         end
      end
      checks++;
      if (bus.match_cnt !== 2'd2 || bus.cnt_sat !== 1'b0) begin
         errors++;
         $display("FAIL t1_cnt got %0d/%b exp 2/0", bus.match_cnt, bus.cnt_sat);
      end
   endtask

   task automatic test_non_overlap();
      logic [6:0] s = 7'b1011011;
      logic [6:0] e = 7'b0001000;
      logic x;
      cfg(8'b0000_1011, 4'd4, 1'b0, 1'b1);
      checks++;
      if (bus.y !== 1'b0 || bus.cfg_err !== 1'b0 || bus.match_cnt !== 2'd0) begin
         errors++;
         $display("FAIL t2_load got y=%b err=%b cnt=%0d exp 0/0/0",
                  bus.y, bus.cfg_err, bus.match_cnt);
      end
      for (int i = 6; i >= 0; i--) begin
         send(1'b1, s[i], e[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t2_y bit%0d got %b exp %b", 7 - i, bus.y, x);
         end
      end
      checks++;
      if (bus.match_cnt !== 2'd1) begin
         errors++;
         $display("FAIL t2_cnt got %0d exp 1", bus.match_cnt);
      end
   endtask

   task automatic test_len3();
      logic [4:0] eo = 5'b00111;
      logic [4:0] en = 5'b00100;
      logic x;
      // upper pattern bits are junk and must be ignored
      cfg(8'b0101_0111, 4'd3, 1'b1, 1'b1);
      for (int i = 4; i >= 0; i--) begin
         send(1'b1, 1'b1, eo[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t3o_y bit%0d got %b exp %b", 5 - i, bus.y, x);
         end
      end
      checks++;
      if (bus.match_cnt !== 2'd3 || bus.cnt_sat !== 1'b1) begin
         errors++;
         $display("FAIL t3o_cnt got %0d/%b exp 3/1", bus.match_cnt, bus.cnt_sat);
      end
      cfg(8'b0000_0111, 4'd3, 1'b0, 1'b1);
      checks++;
      if (bus.match_cnt !== 2'd0 || bus.cnt_sat !== 1'b0) begin
         errors++;
         $display("FAIL t3_clr got %0d/%b exp 0/0", bus.match_cnt, bus.cnt_sat);
      end
      for (int i = 4; i >= 0; i--) begin
         send(1'b1, 1'b1, en[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t3n_y bit%0d got %b exp %b", 5 - i, bus.y, x);
         end
      end
      checks++;
      if (bus.match_cnt !== 2'd1) begin
         errors++;
         $display("FAIL t3n_cnt got %0d exp 1", bus.match_cnt);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] v = 8'b1010_1010;
      logic [7:0] b = 8'b1101_1011;
      logic [7:0] e = 8'b0000_0010;
      logic x;
      cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         send(v[i], b[i], e[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t4_y step%0d got %b exp %b", 8 - i, bus.y, x);
         end
      end
   endtask

   task automatic test_saturate();
      logic [5:0] b = 6'b110111;
      logic [1:0] c[6] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
      logic [5:0] s = 6'b000111;
      logic x;
      cfg(8'b0000_0001, 4'd1, 1'b1, 1'b1);
      for (int i = 5; i >= 0; i--) begin
         send(1'b1, b[i], b[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x || bus.match_cnt !== c[5-i] || bus.cnt_sat !== s[i]) begin
            errors++;
            $display("FAIL t5_sat step%0d got %b/%0d/%b exp %b/%0d/%b", 6 - i,
                     bus.y, bus.match_cnt, bus.cnt_sat, x, c[5-i], s[i]);
         end
      end
      bus.clr_cnt = 1'b1;
      send(1'b1, 1'b1, 1'b1);
      bus.clr_cnt = 1'b0;
      x = sb.pop_front();
      checks++;
      if (bus.y !== x || bus.match_cnt !== 2'd0 || bus.cnt_sat !== 1'b0) begin
         errors++;
         $display("FAIL t5_clr got %b/%0d/%b exp 1/0/0",
                  bus.y, bus.match_cnt, bus.cnt_sat);
      end
      send(1'b1, 1'b1, 1'b1);
      x = sb.pop_front();
      checks++;
      if (bus.y !== x || bus.match_cnt !== 2'd1) begin
         errors++;
         $display("FAIL t5_after got %b/%0d exp 1/1", bus.y, bus.match_cnt);
      end
   endtask

   task automatic test_full_len();
      logic [7:0] s = 8'b1011_0011;
      logic [7:0] e = 8'b0000_0001;
      logic x;
      cfg(8'b1011_0011, 4'd8, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         send(1'b1, s[i], e[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t8_y bit%0d got %b exp %b", 8 - i, bus.y, x);
         end
      end
   endtask

   task automatic test_cfg_err();
      logic [6:0] s = 7'b1011011;
      logic [6:0] e = 7'b0001001;
      logic x;
      cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1);
      cfg(8'b0000_0000, 4'd0, 1'b0, 1'b0);
      checks++;
      if (bus.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL t6_err0 got %b exp 1", bus.cfg_err);
      end
      cfg(8'b1111_1111, 4'd9, 1'b0, 1'b0);
      checks++;
      if (bus.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL t6_err9 got %b exp 1", bus.cfg_err);
      end
      for (int i = 6; i >= 0; i--) begin
         send(1'b1, s[i], e[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x || bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL t6_keep bit%0d got %b/%b exp %b/0",
                     7 - i, bus.y, bus.cfg_err, x);
         end
      end
   endtask

   task automatic test_load_wins();
      logic [2:0] p = 3'b101;
      logic [3:0] s = 4'b1011;
      logic [3:0] e = 4'b0001;
      logic x;
      for (int i = 2; i >= 0; i--) begin
         send(1'b1, p[i], 1'b0);
         void'(sb.pop_front());
      end
      bus.w_vld = 1'b1;
      bus.w     = 1'b1;
      cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0);
      bus.w_vld = 1'b0;
      checks++;
      if (bus.y !== 1'b0) begin
         errors++;
         $display("FAIL t7_drop got %b exp 0", bus.y);
      end
      for (int i = 3; i >= 0; i--) begin
         send(1'b1, s[i], e[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t7_y bit%0d got %b exp %b", 4 - i, bus.y, x);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [2:0] p = 3'b101;
      logic [3:0] s = 4'b1011;
      logic [3:0] e = 4'b0001;
      logic x;
      for (int i = 2; i >= 0; i--) begin
         send(1'b1, p[i], 1'b0);
         void'(sb.pop_front());
      end
      #1 rs_n = 1'b0;
      #1;
      checks++;
      if (bus.y !== 1'b0 || bus.match_cnt !== 2'd0) begin
         errors++;
         $display("FAIL t9_rst got %b/%0d exp 0/0", bus.y, bus.match_cnt);
      end
      #2 rs_n = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         send(1'b1, s[i], e[i]);
         x = sb.pop_front();
         checks++;
         if (bus.y !== x) begin
            errors++;
            $display("FAIL t9_y bit%0d got %b exp %b", 4 - i, bus.y, x);
         end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_len3();
      test_gaps();
      test_saturate();
      test_full_len();
      test_cfg_err();
      test_load_wins();
      test_mid_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_left got %0d exp 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
